// File: rtl/key_voice_arbiter.sv
// rtl/key_voice_arbiter.sv - single-voice key arbiter with debounce and octave control
//
// Purpose : synchronises and debounces NUM_KEYS piano keys plus two octave
//           buttons, grants one key at a time to the tone generator, and
//           keeps a saturating octave register.
// Ports   : clk, rst_n (async, active-low)
//           key[NUM_KEYS-1:0], oct_up, oct_dn  raw asynchronous inputs
//           note[3:0]    index of the granted key
//           octave[2:0]  current octave 0..MAX_OCT
//           tone_en      high while a note sounds
//           busy         high in PLAY or RELEASE
// Option  : define KEY_PREEMPT_EN to let a newly pressed key take over a
//           sounding note without a release gap.
module key_voice_arbiter #(
    parameter int NUM_KEYS     = 7,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int RELEASE_CYC  = 100000,
    parameter int MAX_OCT      = 5,
    parameter int RESET_OCT    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                oct_up,
    input  logic                oct_dn,
    output logic [3:0]          note,
    output logic [2:0]          octave,
    output logic                tone_en,
    output logic                busy
);

    // Keys occupy the low bits; the octave buttons sit above them.
    localparam int NL = NUM_KEYS + 2;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW = $clog2(RELEASE_CYC + 1);

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    logic [NL-1:0]       raw, sync1, sync2, deb;
    logic [DW-1:0]       db_cnt [NL];
    logic [1:0]          oct_q;
    logic [NUM_KEYS-1:0] keys_db, granted_mask;
    logic                up_rise, dn_rise, granted_held, grant_any;
    logic [3:0]          grant_idx;
    logic [RW-1:0]       rel_cnt;
    state_t              state;

    assign raw = {oct_dn, oct_up, key};

    // Two-flop synchroniser, then a per-line stability counter. The counter
    // only runs while the synced level disagrees with the debounced level,
    // so any glitch shorter than DEBOUNCE_CYC cycles restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            oct_q <= '0;
            for (int i = 0; i < NL; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            oct_q <= deb[NL-1:NUM_KEYS];
            for (int i = 0; i < NL; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign keys_db      = deb[NUM_KEYS-1:0];
    assign up_rise      = deb[NUM_KEYS]     & ~oct_q[0];
    assign dn_rise      = deb[NUM_KEYS + 1] & ~oct_q[1];
    assign granted_mask = NUM_KEYS'(1) << note;
    assign granted_held = |(keys_db & granted_mask);

    // Lowest pressed index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys_db[i]) begin
                grant_any = 1'b1;
                grant_idx = 4'(i);
            end
        end
    end

`ifdef KEY_PREEMPT_EN
    logic [NUM_KEYS-1:0] key_q, pre_rise;
    logic                pre_any;
    logic [3:0]          pre_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= '0;
        else        key_q <= keys_db;
    end

    // Fresh presses of any key other than the one sounding.
    assign pre_rise = keys_db & ~key_q & ~granted_mask;

    always_comb begin
        pre_any = 1'b0;
        pre_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pre_rise[i]) begin
                pre_any = 1'b1;
                pre_idx = 4'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            note    <= '0;
            octave  <= 3'(RESET_OCT);
            tone_en <= 1'b0;
            busy    <= 1'b0;
            rel_cnt <= '0;
        end else begin
            // Simultaneous up and down presses cancel out.
            if (up_rise && !dn_rise && octave != 3'(MAX_OCT))
                octave <= octave + 3'd1;
            else if (dn_rise && !up_rise && octave != 3'd0)
                octave <= octave - 3'd1;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        note    <= grant_idx;
                        tone_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= PLAY;
                    end
                end
                PLAY: begin
                    // Releasing the granted key always ends the note, even
                    // if other keys remain held.
                    if (!granted_held) begin
                        tone_en <= 1'b0;
                        rel_cnt <= RW'(RELEASE_CYC - 1);
                        state   <= RELEASE;
                    end
`ifdef KEY_PREEMPT_EN
                    else if (pre_any) begin
                        note <= pre_idx;
                    end
`endif
                end
                RELEASE: begin
                    if (rel_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_voice_arbiter.sv
// tb/tb_key_voice_arbiter.sv - self-checking bench for key_voice_arbiter
module tb_key_voice_arbiter;

    localparam int NK   = 7;
    localparam int D    = 4;
    localparam int R    = 3;
    localparam int MAXO = 5;
    localparam int RSTO = 2;
    localparam int NL   = NK + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '0;
    logic          oct_up = 1'b0;
    logic          oct_dn = 1'b0;
    logic [3:0]    note;
    logic [2:0]    octave;
    logic          tone_en;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    key_voice_arbiter #(
        .NUM_KEYS(NK), .DEBOUNCE_CYC(D), .RELEASE_CYC(R),
        .MAX_OCT(MAXO), .RESET_OCT(RSTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .oct_up(oct_up), .oct_dn(oct_dn),
        .note(note), .octave(octave), .tone_en(tone_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples delayed two edges, a level that flips once
    // it has disagreed with the delayed sample for D edges in a row, and a
    // voice described by "playing", "quiet edges left" and "note".
    logic [NL-1:0] m_h1, m_h2, m_deb, m_debp;
    int            m_run [NL];
    int            m_oct, m_note, m_quiet;
    bit            m_tone, m_busy;

    function automatic int lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [8:0] m_out();
        return {4'(m_note), 3'(m_oct), m_tone, m_busy};
    endfunction

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_deb = '0; m_debp = '0;
        for (int i = 0; i < NL; i++) m_run[i] = 0;
        m_oct = RSTO; m_note = 0; m_quiet = 0; m_tone = 0; m_busy = 0;
    endtask

    task automatic model_edge();
        logic [NL-1:0] raw, old_deb, rise;
        logic [NK-1:0] kd, kr, held;
        raw     = {oct_dn, oct_up, key};
        old_deb = m_deb;
        rise    = m_deb & ~m_debp;
        for (int i = 0; i < NL; i++) begin
            if (m_h2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = ~m_deb[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_debp = old_deb;
        m_h2   = m_h1;
        m_h1   = raw;
        if (rise[NK] && !rise[NK+1] && m_oct < MAXO) m_oct++;
        if (rise[NK+1] && !rise[NK] && m_oct > 0) m_oct--;
        kd = old_deb[NK-1:0];
        kr = rise[NK-1:0];
        if (!m_busy) begin
            if (kd != 0) begin
                m_note = lowest(kd); m_tone = 1; m_busy = 1;
            end
        end else if (m_tone) begin
            held = kd >> m_note;
            if (!held[0]) begin
                m_tone = 0; m_quiet = R;
            end
`ifdef KEY_PREEMPT_EN
            else begin
                kr = kr & ~(NK'(1) << m_note);
                if (kr != 0) m_note = lowest(kr);
            end
`endif
        end else begin
            m_quiet--;
            if (m_quiet == 0) m_busy = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        vectors++;
        if ({note, octave, tone_en, busy} !== {4'd0, 3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", {note, octave, tone_en, busy}, {4'd0, 3'd2, 2'b00});
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            vectors++;
            if ({note, octave, tone_en, busy} !== {4'd0, 3'd2, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL idle_state: got %h want %h", {note, octave, tone_en, busy}, {4'd0, 3'd2, 2'b00});
            end
        end
    endtask

    task automatic test_grant_timing();
        int tone_fall, busy_fall;
        key[4] = 1'b1;
        for (int e = 1; e <= 3 + D; e++) begin
            tick();
            vectors++;
            if (tone_en !== (e == 3 + D)) begin
                errors++;
                $display("FAIL press_to_tone edge %0d: tone_en=%b want %b", e, tone_en, e == 3 + D);
            end
        end
        vectors++;
        if (note !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_note: note=%0d busy=%b want 4 1", note, busy);
        end
        key[4] = 1'b0;
        tone_fall = -1;
        busy_fall = -1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            vectors++;
            if ({note, octave, tone_en, busy} !== m_out()) begin
                errors++;
                $display("FAIL release_seq edge %0d: got %h want %h", e, {note, octave, tone_en, busy}, m_out());
            end
            if (tone_fall < 0 && !tone_en) tone_fall = e;
            if (busy_fall < 0 && !busy) busy_fall = e;
        end
        vectors++;
        if (tone_fall < 0 || busy_fall - tone_fall != R) begin
            errors++;
            $display("FAIL release_gap: tone fell %0d busy fell %0d want gap %0d", tone_fall, busy_fall, R);
        end
    endtask

    task automatic test_simultaneous();
        int want;
        key[5] = 1'b1;
        key[2] = 1'b1;
        repeat (3 + D) tick();
        vectors++;
        if (note !== 4'd2 || tone_en !== 1'b1) begin
            errors++;
            $display("FAIL simul_lowest: note=%0d tone_en=%b want 2 1", note, tone_en);
        end
        key[6] = 1'b1;
        repeat (12) begin
            tick();
            vectors++;
            if (tone_en !== 1'b1 || {note, octave, tone_en, busy} !== m_out()) begin
                errors++;
                $display("FAIL hold_tone: got %h want %h", {note, octave, tone_en, busy}, m_out());
            end
        end
`ifdef KEY_PREEMPT_EN
        want = 6;
`else
        want = 2;
`endif
        vectors++;
        if (note !== 4'(want)) begin
            errors++;
            $display("FAIL preempt_note: note=%0d want %0d", note, want);
        end
        key = '0;
        repeat (20) tick();
    endtask

    task automatic test_glitch();
        key[1] = 1'b1;
        repeat (3) tick();
        key[1] = 1'b0;
        repeat (15) begin
            tick();
            vectors++;
            if (tone_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL glitch: tone_en=%b busy=%b want 0 0", tone_en, busy);
            end
        end
    endtask

    task automatic test_octave();
        int up_exp [4] = '{3, 4, 5, 5};
        int dn_exp [6] = '{4, 3, 2, 1, 0, 0};
        for (int p = 0; p < 4; p++) begin
            oct_up = 1'b1; repeat (10) tick();
            oct_up = 1'b0; repeat (10) tick();
            vectors++;
            if (octave !== 3'(up_exp[p]) || octave !== 3'(m_oct)) begin
                errors++;
                $display("FAIL oct_up %0d: octave=%0d want %0d", p, octave, up_exp[p]);
            end
        end
        for (int p = 0; p < 6; p++) begin
            oct_dn = 1'b1; repeat (10) tick();
            oct_dn = 1'b0; repeat (10) tick();
            vectors++;
            if (octave !== 3'(dn_exp[p])) begin
                errors++;
                $display("FAIL oct_dn %0d: octave=%0d want %0d", p, octave, dn_exp[p]);
            end
        end
        oct_up = 1'b1; repeat (10) tick();
        oct_up = 1'b0; repeat (10) tick();
        oct_up = 1'b1; oct_dn = 1'b1; repeat (10) tick();
        oct_up = 1'b0; oct_dn = 1'b0; repeat (10) tick();
        vectors++;
        if (octave !== 3'd1) begin
            errors++;
            $display("FAIL oct_both: octave=%0d want 1", octave);
        end
    endtask

    task automatic test_async_reset();
        key[3] = 1'b1;
        repeat (3 + D) tick();
        vectors++;
        if (note !== 4'd3 || tone_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_grant: note=%0d tone_en=%b want 3 1", note, tone_en);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (tone_en !== 1'b0 || busy !== 1'b0 || octave !== 3'd2) begin
            errors++;
            $display("FAIL async_reset: tone_en=%b busy=%b octave=%0d want 0 0 2", tone_en, busy, octave);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 3 + D; e++) begin
            tick();
            vectors++;
            if (tone_en !== (e == 3 + D)) begin
                errors++;
                $display("FAIL regrant edge %0d: tone_en=%b want %b", e, tone_en, e == 3 + D);
            end
        end
        vectors++;
        if (note !== 4'd3) begin
            errors++;
            $display("FAIL regrant_note: note=%0d want 3", note);
        end
        key = '0;
        repeat (20) tick();
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 120; s++) begin
            key    = NK'($urandom_range(0, 127) & $urandom_range(0, 127));
            oct_up = ($urandom_range(0, 5) == 0);
            oct_dn = ($urandom_range(0, 5) == 0);
            hold   = $urandom_range(1, 12);
            repeat (hold) begin
                tick();
                vectors++;
                if ({note, octave, tone_en, busy} !== m_out()) begin
                    errors++;
                    $display("FAIL random seg %0d: got %h want %h", s, {note, octave, tone_en, busy}, m_out());
                end
            end
        end
        key = '0; oct_up = 1'b0; oct_dn = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_grant_timing();
        test_simultaneous();
        test_glitch();
        test_octave();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
